// File: rtl/acc_responder_if.sv
// Request/response bundle between an acc_interconnect master port and an accelerator responder.
interface acc_responder_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 4,
  parameter int IdWidth   = 3
);
  logic [AddrWidth-1:0] q_addr;
  logic [IdWidth-1:0]   q_id;
  logic [31:0]          q_data_op;
  logic [DataWidth-1:0] q_data_arga;
  logic [DataWidth-1:0] q_data_argb;
  logic [DataWidth-1:0] q_data_argc;
  logic                 q_valid;
  logic                 q_ready;
  logic [DataWidth-1:0] p_data0;
  logic [DataWidth-1:0] p_data1;
  logic                 p_dual_writeback;
  logic [IdWidth-1:0]   p_id;
  logic [4:0]           p_rd;
  logic                 p_error;
  logic                 p_valid;
  logic                 p_ready;

  modport master (
    output q_addr, q_id, q_data_op, q_data_arga, q_data_argb, q_data_argc, q_valid, p_ready,
    input  q_ready, p_data0, p_data1, p_dual_writeback, p_id, p_rd, p_error, p_valid
  );

  modport slave (
    input  q_addr, q_id, q_data_op, q_data_arga, q_data_argb, q_data_argc, q_valid, p_ready,
    output q_ready, p_data0, p_data1, p_dual_writeback, p_id, p_rd, p_error, p_valid
  );
endinterface

// File: rtl/acc_responder.sv
// Reference accelerator responder: fixed-latency integer op pipeline feeding a credit-protected
// fall-through response FIFO. Optional counters enabled by ACC_RESPONDER_STATS_EN.
module acc_responder #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 4,
  parameter int IdWidth   = 3,
  parameter int Addr      = 0,
  parameter int Latency   = 2,
  parameter int FifoDepth = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  acc_responder_if.slave  bus,
  output logic            busy
`ifdef ACC_RESPONDER_STATS_EN
  ,
  output logic [15:0]     stat_req,
  output logic [15:0]     stat_rsp,
  output logic [15:0]     stat_err
`endif
);

  localparam int OccW = $clog2(FifoDepth + 1);
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [AddrWidth-1:0] LP_ADDR = AddrWidth'(Addr);

  typedef struct packed {
    logic [DataWidth-1:0] data0;
    logic [DataWidth-1:0] data1;
    logic                 dual;
    logic [IdWidth-1:0]   id;
    logic [4:0]           rd;
    logic                 err;
  } rsp_t;

  function automatic rsp_t decode(input logic [AddrWidth-1:0] addr,
                                  input logic [IdWidth-1:0]   id,
                                  input logic [2:0]           funct3,
                                  input logic [4:0]           rd,
                                  input logic [DataWidth-1:0] a,
                                  input logic [DataWidth-1:0] b,
                                  input logic [DataWidth-1:0] c);
    logic [2*DataWidth-1:0] prod;
    rsp_t r;
    r      = '0;
    r.id   = id;
    r.rd   = rd;
    prod   = {{DataWidth{1'b0}}, a} * {{DataWidth{1'b0}}, b};
    if (addr != LP_ADDR) begin
      r.err = 1'b1;
    end else begin
      case (funct3)
        3'd0: r.data0 = a + b;
        3'd1: r.data0 = a - b;
        3'd2: r.data0 = a ^ b;
        3'd3: begin
          r.data0 = prod[DataWidth-1:0];
          r.data1 = prod[2*DataWidth-1:DataWidth];
          r.dual  = 1'b1;
        end
        3'd4: r.data0 = prod[DataWidth-1:0] + c;
        3'd5: r.err   = 1'b0;
        default: r.err = 1'b1;
      endcase
    end
    return r;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [OccW-1:0]    r_occ;
  logic [OccW-1:0]    w_occ_nxt;
  logic [OccW-1:0]    r_cnt;
  logic [PtrW-1:0]    r_wptr;
  logic [PtrW-1:0]    r_rptr;
  logic [Latency-1:0] r_vld_p;
  logic [Latency-1:0] r_wr_p;
  rsp_t               r_pl_p [Latency];
  rsp_t               r_mem  [FifoDepth];
  rsp_t               w_dec;
  rsp_t               w_head;
  rsp_t               w_out;
  logic               w_dec_wr;
  logic               w_q_ready;
  logic               w_acc;
  logic               w_nonempty;
  logic               w_pop;
  logic               w_fifo_wr;
  logic               w_rel;
  logic               w_unused;

  assign w_unused = ^{bus.q_data_op[31:15], bus.q_data_op[6:0]};

  // Credits are tracked in registered state only, so q_ready never sees p_ready combinationally.
  assign w_q_ready  = ~rst_n & (r_occ < OccW'(FifoDepth));
  assign w_acc      = bus.q_valid & w_q_ready;
  assign w_nonempty = (r_cnt != '0);
  assign w_pop      = w_nonempty & bus.p_ready;
  assign w_fifo_wr  = r_vld_p[Latency-1] & r_wr_p[Latency-1];
  assign w_rel      = r_vld_p[Latency-1] & ~r_wr_p[Latency-1];

  assign w_dec    = decode(bus.q_addr, bus.q_id, bus.q_data_op[14:12], bus.q_data_op[11:7],
                           bus.q_data_arga, bus.q_data_argb, bus.q_data_argc);
  assign w_dec_wr = !((bus.q_data_op[14:12] == 3'd5) && (bus.q_addr == LP_ADDR));

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_acc) w_occ_nxt = w_occ_nxt + OccW'(1);
    if (w_pop) w_occ_nxt = w_occ_nxt - OccW'(1);
    if (w_rel) w_occ_nxt = w_occ_nxt - OccW'(1);
  end

  // Stage p0 captures the decoded result at accept; later stages only shift.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_vld_p <= '0;
      r_wr_p  <= '0;
    end else begin
      r_vld_p[0] <= w_acc;
      r_wr_p[0]  <= w_dec_wr;
      for (int i = 1; i < Latency; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_wr_p[i]  <= r_wr_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_pl_p[0] <= w_dec;
    for (int i = 1; i < Latency; i++) r_pl_p[i] <= r_pl_p[i-1];
    if (w_fifo_wr) r_mem[r_wptr] <= r_pl_p[Latency-1];
  end

  // FIFO write boundary: last pipeline stage enters the fall-through FIFO.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_occ  <= '0;
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_occ <= w_occ_nxt;
      if (w_fifo_wr) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)     r_rptr <= ptr_inc(r_rptr);
      case ({w_fifo_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + OccW'(1);
        2'b01:   r_cnt <= r_cnt - OccW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_head = r_mem[r_rptr];
  assign w_out  = w_nonempty ? w_head : '0;

  assign bus.q_ready          = w_q_ready;
  assign bus.p_valid          = w_nonempty;
  assign bus.p_data0          = w_out.data0;
  assign bus.p_data1          = w_out.data1;
  assign bus.p_dual_writeback = w_out.dual;
  assign bus.p_id             = w_out.id;
  assign bus.p_rd             = w_out.rd;
  assign bus.p_error          = w_out.err;
  assign busy                 = (r_occ != '0);

`ifdef ACC_RESPONDER_STATS_EN
  logic [15:0] r_stat_req;
  logic [15:0] r_stat_rsp;
  logic [15:0] r_stat_err;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_stat_req <= '0;
      r_stat_rsp <= '0;
      r_stat_err <= '0;
    end else begin
      if (w_acc)               r_stat_req <= r_stat_req + 16'd1;
      if (w_pop)               r_stat_rsp <= r_stat_rsp + 16'd1;
      if (w_pop && w_head.err) r_stat_err <= r_stat_err + 16'd1;
    end
  end

  assign stat_req = r_stat_req;
  assign stat_rsp = r_stat_rsp;
  assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_acc_responder.sv
// Self-checking bench for acc_responder: vector table, corner sequences and a randomized
// run against a queue-based reference model of the credit/latency/ordering rules.
module tb_acc_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
`ifdef ACC_RESPONDER_STATS_EN
  logic [15:0] stat_req, stat_rsp, stat_err;
`endif

  acc_responder_if #(.DataWidth(32), .AddrWidth(4), .IdWidth(3)) ifc ();

  acc_responder #(
    .DataWidth(32), .AddrWidth(4), .IdWidth(3), .Addr(0), .Latency(LAT), .FifoDepth(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave),
    .busy  (busy)
`ifdef ACC_RESPONDER_STATS_EN
    ,
    .stat_req (stat_req),
    .stat_rsp (stat_rsp),
    .stat_err (stat_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        dual;
    logic        err;
    logic        rsp;
    logic [2:0]  id;
    logic [4:0]  rd;
    int          rdy;
  } exp_t;

  typedef struct {
    logic [3:0]  addr;
    logic [2:0]  f3;
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [31:0] a, b, c, d0, d1;
    logic        dual, err, rsp;
  } vec_t;

  exp_t rsp_q[$];
  int   nor_q[$];
  exp_t cur_exp;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_acc = 0;
  int   n_pop = 0;
  bit   last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ref_rsp(input logic [3:0] addr, input logic [2:0] f3,
                                   input logic [2:0] id, input logic [4:0] rd,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c);
    exp_t e;
    longint unsigned prod;
    prod = longint'(a) * longint'(b);
    e = '{d0: 0, d1: 0, dual: 0, err: 0, rsp: 1, id: id, rd: rd, rdy: 0};
    if (addr != 4'd0) e.err = 1;
    else if (f3 == 3'd0) e.d0 = a + b;
    else if (f3 == 3'd1) e.d0 = a - b;
    else if (f3 == 3'd2) e.d0 = a ^ b;
    else if (f3 == 3'd3) begin e.d0 = prod[31:0]; e.d1 = prod[63:32]; e.dual = 1; end
    else if (f3 == 3'd4) e.d0 = 32'(prod + longint'(c));
    else if (f3 == 3'd5) e.rsp = 0;
    else e.err = 1;
    return e;
  endfunction

  task automatic set_req(input logic [3:0] addr, input logic [2:0] f3, input logic [2:0] id,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [16:0] junk);
    ifc.q_addr      = addr;
    ifc.q_id        = id;
    ifc.q_data_op   = {junk, f3, rd, 7'h0b};
    ifc.q_data_arga = a;
    ifc.q_data_argb = b;
    ifc.q_data_argc = c;
    ifc.q_valid     = 1'b1;
    cur_exp         = ref_rsp(addr, f3, id, rd, a, b, c);
  endtask

  // One clock: observe at negedge+1, update model with the handshakes of the coming posedge.
  task automatic step();
    int  occ;
    bit  exp_pv;
    exp_t e;
    #1;
    while (nor_q.size() > 0 && nor_q[0] <= cyc) void'(nor_q.pop_front());
    occ    = rsp_q.size() + nor_q.size();
    exp_pv = (rsp_q.size() > 0) && (rsp_q[0].rdy <= cyc);
    chk("q_ready", 64'(ifc.q_ready), 64'((occ < DEPTH) && !rst_n));
    chk("p_valid", 64'(ifc.p_valid), 64'(exp_pv));
    chk("busy",    64'(busy),        64'(occ != 0));
    if (rst_n) begin
      chk("rst_p_data0", 64'(ifc.p_data0), 64'd0);
      chk("rst_p_id",    64'(ifc.p_id),    64'd0);
    end
    if (ifc.p_valid && exp_pv) begin
      e = rsp_q[0];
      chk("p_data0", 64'(ifc.p_data0), 64'(e.d0));
      chk("p_data1", 64'(ifc.p_data1), 64'(e.d1));
      chk("p_dual",  64'(ifc.p_dual_writeback), 64'(e.dual));
      chk("p_error", 64'(ifc.p_error), 64'(e.err));
      chk("p_id",    64'(ifc.p_id),    64'(e.id));
      chk("p_rd",    64'(ifc.p_rd),    64'(e.rd));
    end
    if (ifc.p_valid && ifc.p_ready) begin
      n_pop++;
      if (rsp_q.size() > 0) void'(rsp_q.pop_front());
    end
    last_acc = ifc.q_valid && ifc.q_ready && !rst_n;
    if (last_acc) begin
      n_acc++;
      e = cur_exp;
      e.rdy = cyc + LAT + 1;
      if (e.rsp) rsp_q.push_back(e);
      else nor_q.push_back(cyc + LAT + 1);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    ifc.q_valid = 1'b0;
    while (i < budget && (rsp_q.size() > 0 || nor_q.size() > 0)) begin
      step();
      i++;
    end
    step();
    if (rsp_q.size() > 0 || nor_q.size() > 0) begin
      chk("drain_timeout", 64'(rsp_q.size() + nor_q.size()), 64'd0);
      rsp_q.delete();
      nor_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    rsp_q.delete();
    nor_q.delete();
    step();
    rst_n = 1'b0;
    step();
  endtask

  vec_t vt[13];

  initial begin
    int k, n0;
    vt[0]  = '{4'd0, 3'd0, 3'd3, 5'd10, 32'd5, 32'd7, 32'd0, 32'd12, 32'd0, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{4'd0, 3'd3, 3'd1, 5'd2, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 32'd1, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{4'd0, 3'd1, 3'd2, 5'd3, 32'd3, 32'd5, 32'd0, 32'hFFFFFFFE, 32'd0, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{4'd0, 3'd2, 3'd4, 5'd4, 32'hA5A5A5A5, 32'hFFFF0000, 32'd0, 32'h5A5AA5A5, 32'd0, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{4'd0, 3'd4, 3'd5, 5'd5, 32'd3, 32'd4, 32'd10, 32'd22, 32'd0, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{4'd0, 3'd4, 3'd6, 5'd6, 32'h80000000, 32'd2, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{4'd0, 3'd0, 3'd7, 5'd31, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{4'd1, 3'd0, 3'd0, 5'd7, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1};
    vt[8]  = '{4'd0, 3'd7, 3'd1, 5'd8, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1};
    vt[9]  = '{4'd0, 3'd5, 3'd2, 5'd9, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{4'd1, 3'd5, 3'd3, 5'd11, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1};
    vt[11] = '{4'd0, 3'd6, 3'd4, 5'd12, 32'd9, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1};
    vt[12] = '{4'd0, 3'd3, 3'd5, 5'd13, 32'h00010000, 32'h00010000, 32'd0, 32'd0, 32'd1, 1'b1, 1'b0, 1'b1};

    set_req(4'd0, 3'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 17'd0);
    ifc.q_valid = 1'b0;
    ifc.p_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b0;
    step();

    // Vector table, one request at a time with p_ready high.
    for (int i = 0; i < 13; i++) begin
      set_req(vt[i].addr, vt[i].f3, vt[i].id, vt[i].rd, vt[i].a, vt[i].b, vt[i].c, 17'h1ABCD);
      cur_exp.d0   = vt[i].d0;
      cur_exp.d1   = vt[i].d1;
      cur_exp.dual = vt[i].dual;
      cur_exp.err  = vt[i].err;
      cur_exp.rsp  = vt[i].rsp;
      n0 = n_pop;
      step();
      chk("vec_accept", 64'(last_acc), 64'd1);
      drain(20);
      chk("vec_rsp_count", 64'(n_pop - n0), 64'(vt[i].rsp));
    end

    // Backpressure: offer 6 ADDs with p_ready low; only DEPTH fit.
    ifc.p_ready = 1'b0;
    n0 = n_acc;
    k = 0;
    repeat (12) begin
      set_req(4'd0, 3'd0, 3'(k), 5'(k + 1), 32'(100 * k), 32'd1, 32'd0, 17'd0);
      step();
      if (last_acc && k < 5) k++;
    end
    chk("bp_accepted", 64'(n_acc - n0), 64'(DEPTH));
    ifc.q_valid = 1'b0;
    ifc.p_ready = 1'b1;
    n0 = n_pop;
    drain(30);
    chk("bp_responses", 64'(n_pop - n0), 64'(DEPTH));

    // Reset while responses are queued and pipeline is busy.
    ifc.p_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(4'd0, 3'd2, 3'(i), 5'(i), 32'(i), 32'hFF, 32'd0, 17'd0);
      step();
    end
    ifc.q_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    rsp_q.delete();
    nor_q.delete();
    step();
    rst_n = 1'b0;
    ifc.p_ready = 1'b1;
    n0 = n_pop;
    repeat (8) step();
    chk("rst_no_stale", 64'(n_pop - n0), 64'd0);

    // Randomized traffic against the model.
    ifc.q_valid = 1'b0;
    repeat (600) begin
      if (!ifc.q_valid || last_acc) begin
        if ($urandom_range(0, 3) != 0)
          set_req(($urandom_range(0, 5) == 0) ? 4'd1 : 4'd0, 3'($urandom_range(0, 7)),
                  3'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 17'($urandom));
        else
          ifc.q_valid = 1'b0;
      end
      ifc.p_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    ifc.p_ready = 1'b1;
    drain(40);

`ifdef ACC_RESPONDER_STATS_EN
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_req((i == 3 || i == 8) ? 4'd1 : 4'd0, 3'd0, 3'(i), 5'(i), 32'(i), 32'd1, 32'd0, 17'd0);
      step();
      while (!last_acc && ifc.q_valid) step();
    end
    drain(30);
    chk("stat_req", 64'(stat_req), 64'd12);
    chk("stat_rsp", 64'(stat_rsp), 64'd12);
    chk("stat_err", 64'(stat_err), 64'd2);
`else
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/acc_responder.md
Name: acc_responder

Overview:
- Accelerator-side responder (slave end) of the acc_interface request/response protocol; it sits on one `acc_c_mst` port of an `acc_interconnect` level.
- Accepts offloaded requests and executes a small integer op set over a fixed-latency pipeline.
- Returns responses in order through a credit-protected output FIFO, with full `p_ready` backpressure support.
- Used as the synthesizable reference accelerator for interconnect bring-up and as an example slave.

Parameters:
- DataWidth, 32, width of operands and results.
- AddrWidth, 4, width of `q_addr`; must match the interconnect `HierAddrWidth + AccAddrWidth`.
- IdWidth, 3, width of `q_id`/`p_id` (extended ID from interconnect).
- Addr, 0, address this responder owns.
- Latency, 2, pipeline stages from accept to FIFO write; must be ≥1.
- FifoDepth, 4, response FIFO entries; must be ≥1.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-high.
- q_addr, in, AddrWidth, target accelerator address.
- q_id, in, IdWidth, request ID.
- q_data_op, in, 32, instruction word: rd = [11:7], funct3 = [14:12].
- q_data_arga, in, DataWidth, operand A.
- q_data_argb, in, DataWidth, operand B.
- q_data_argc, in, DataWidth, operand C (unused except by MAC).
- q_valid, in, 1, request valid.
- q_ready, out, 1, request ready.
- p_data0, out, DataWidth, result / low half.
- p_data1, out, DataWidth, high half (MUL) else 0.
- p_dual_writeback, out, 1, p_data1 valid.
- p_id, out, IdWidth, echoed q_id.
- p_rd, out, 5, echoed rd.
- p_error, out, 1, error response.
- p_valid, out, 1, response valid.
- p_ready, in, 1, response ready.
- busy, out, 1, pipeline or FIFO non-empty.

Behaviour:
- Handshakes: accept on q_valid&q_ready; deliver on p_valid&p_ready. p_* fields hold stable while p_valid=1 and p_ready=0.
- Reset (rst_n=1): all outputs 0; pipeline, FIFO and credit counter cleared. Reset mid-operation drops every in-flight and queued response silently.
- Credits:
  - occ = FIFO entries + valid pipeline stages, a registered count.
  - q_ready = (occ < FifoDepth), a function of registered state only; no combinational path from p_ready.
  - An entry popped in cycle N frees its credit from cycle N+1.
  - Simultaneous accept and pop: occ unchanged.
  - FIFO overflow is impossible by construction.
- Decode by funct3, in the first stage:
  - 0 ADD: data0 = A+B.
  - 1 SUB: data0 = A−B.
  - 2 XOR: data0 = A^B.
  - 3 MUL: full 2·DataWidth unsigned product; data0 = low half, data1 = high half, dual_writeback = 1.
  - 4 MAC: data0 = A*B+C, truncated mod 2^DataWidth.
  - 5 NORSP: travels the pipeline holding a credit, is not written to the FIFO, and releases its credit at the FIFO-write edge.
  - 6, 7: error response, data0 = data1 = 0.
- Address check: q_addr ≠ Addr gives an error response regardless of funct3, including NORSP. data0 = data1 = 0 and p_error = 1.
- Wrap-around arithmetic, no saturation. data1 = 0 and dual_writeback = 0 for all non-MUL ops.
- Latency:
  - A request accepted at edge N is written to the FIFO at edge N+Latency.
  - The FIFO is fall-through, so p_valid can rise in the cycle following edge N+Latency.
  - Pipeline never stalls; credits guarantee a FIFO slot.
- Ordering: responses leave strictly in accept order. p_id and p_rd are copied unchanged.
- busy = (occ ≠ 0).

Optional Feature:
- Macro: ACC_RESPONDER_STATS_EN.
- Defined: adds three output ports, each 16 bits wide and counting mod 2^16, cleared by reset:
  - stat_req: incremented on every accept.
  - stat_rsp: incremented on every p handshake.
  - stat_err: incremented on every p handshake with p_error = 1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- ADD, defaults (Latency = 2): A = 5, B = 7, id = 3, rd = 10, accepted at edge 0, p_ready = 1. Expect p_valid after edge 2 with data0 = 12, p_id = 3, p_rd = 10, p_error = 0, dual_writeback = 0.
- MUL: A = 0xFFFFFFFF, B = 2. Expect data0 = 0xFFFFFFFE, data1 = 0x1, dual_writeback = 1.
- Backpressure: hold p_ready = 0 and stream 6 ADDs. Expect exactly 4 accepted, with q_ready low thereafter. Release p_ready; expect 4 in-order responses, then q_ready rises one cycle after the first pop.
- Errors:
  - q_addr = Addr+1 with ADD: expect p_error = 1, data0 = 0.
  - funct3 = 7: expect p_error = 1.
  - funct3 = 5: expect no response and busy returning to 0 after Latency cycles.
- Reset mid-flight: 3 requests queued with p_ready = 0; pulse rst_n = 1 for one cycle. Expect p_valid = 0, busy = 0 and q_ready = 1 afterwards, and no stale response appears later.
- ACC_RESPONDER_STATS_EN: after 10 ADDs and 2 bad-address requests, all acknowledged. Expect stat_req = 12, stat_rsp = 12, stat_err = 2.
